// File: rtl/message_loc_ctrl.sv
// Sequencer for the FIX message-location store: begin/end events become slot writes, committed
// slots are read back into a valid/ready queue. MSG_LOC_STATS_EN adds commit/drop counters.
module message_loc_ctrl #(
    parameter int DATA_WIDTH  = 5,
    parameter int NUM_MESSAGE = 10,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_begin_i,
    input  logic                  msg_end_i,
    input  logic [DATA_WIDTH-1:0] pos_i,
    output logic                  store_start_o,
    output logic                  store_end_o,
    output logic [DATA_WIDTH-1:0] start_o,
    output logic [DATA_WIDTH-1:0] end_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  re_o,
    output logic                  read_start_o,
    output logic                  read_end_o,
    input  logic [DATA_WIDTH-1:0] mem_start_i,
    input  logic [DATA_WIDTH-1:0] mem_end_i,
    output logic                  msg_valid_o,
    input  logic                  msg_ready_i,
    output logic [DATA_WIDTH-1:0] msg_start_o,
    output logic [DATA_WIDTH-1:0] msg_end_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  proto_err_o
`ifdef MSG_LOC_STATS_EN
    ,
    output logic [15:0]           stat_commit_o,
    output logic [15:0]           stat_drop_o
`endif
);
    typedef enum logic [1:0] {W_IDLE, W_MSG, W_DROP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_HOLD} r_state_e;

    typedef struct packed {
        logic                  vld;
        logic                  is_end;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] pos;
    } wr_t;

    localparam logic [ADDR_WIDTH:0]   NUM_CNT   = (ADDR_WIDTH+1)'(NUM_MESSAGE);
    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(NUM_MESSAGE - 1);

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    w_state_e              w_state_q, w_state_d, w_mid;
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d, cnt_mid;
    logic                  overflow_q, overflow_d, proto_err_q, proto_err_d;
    wr_t                   pend_q, pend_d;
    wr_t                   end_wr, start_wr, first_wr, second_wr, wr_out;
    logic                  commit, drop, pop;

    logic                  store_start_q, store_start_d, store_end_q, store_end_d;
    logic [DATA_WIDTH-1:0] start_q, start_d, end_q, end_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  re_q, re_d, msg_valid_q, msg_valid_d;

    // Write side: the end event is resolved first, then begin is evaluated from the resulting state.
    always_comb begin
        w_mid       = w_state_q;
        w_state_d   = w_state_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        commit      = 1'b0;
        drop        = 1'b0;
        end_wr      = '0;
        start_wr    = '0;

        if (msg_end_i) begin
            case (w_state_q)
                W_IDLE: proto_err_d = 1'b1;
                W_MSG: begin
                    commit = 1'b1;
                    end_wr = '{vld: 1'b1, is_end: 1'b1, addr: wr_ptr_q, pos: pos_i};
                    w_mid  = W_IDLE;
                end
                default: w_mid = W_IDLE;
            endcase
        end

        wr_ptr_d  = commit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_mid   = count_q + {{ADDR_WIDTH{1'b0}}, commit};
        w_state_d = w_mid;

        if (msg_begin_i) begin
            case (w_mid)
                W_IDLE: begin
                    if (cnt_mid >= NUM_CNT) begin
                        drop      = 1'b1;
                        w_state_d = W_DROP;
                    end else begin
                        start_wr  = '{vld: 1'b1, is_end: 1'b0, addr: wr_ptr_d, pos: pos_i};
                        w_state_d = W_MSG;
                    end
                end
                W_MSG: begin
                    proto_err_d = 1'b1;
                    start_wr    = '{vld: 1'b1, is_end: 1'b0, addr: wr_ptr_d, pos: pos_i};
                end
                default: ;
            endcase
        end
        overflow_d = overflow_q | drop;

        // One store write per cycle; the second write of a begin+end cycle waits in pend_q.
        // Events closer than two cycles after such a pair are not produced by the delimiter detector.
        first_wr  = commit ? end_wr : start_wr;
        second_wr = commit ? start_wr : '0;
        if (pend_q.vld) begin
            wr_out = pend_q;
            pend_d = first_wr;
        end else begin
            wr_out = first_wr;
            pend_d = second_wr;
        end
    end

    // Read side: a read is only issued into a cycle with no store strobe.
    always_comb begin
        r_state_d = r_state_q;
        rd_ptr_d  = rd_ptr_q;
        pop       = 1'b0;
        case (r_state_q)
            R_IDLE:  if (count_q != '0 && !wr_out.vld) r_state_d = R_ISSUE;
            R_ISSUE: r_state_d = R_HOLD;
            R_HOLD: begin
                if (msg_ready_i) begin
                    pop       = 1'b1;
                    rd_ptr_d  = ptr_inc(rd_ptr_q);
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        count_d = count_q;
        if (commit && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !commit)
            count_d = count_q - 1'b1;

        store_start_d = wr_out.vld && !wr_out.is_end;
        store_end_d   = wr_out.vld && wr_out.is_end;
        start_d       = store_start_d ? wr_out.pos : start_q;
        end_d         = store_end_d ? wr_out.pos : end_q;
        re_d          = (r_state_d == R_ISSUE);
        addr_d        = wr_out.vld ? wr_out.addr : (re_d ? rd_ptr_q : addr_q);
        msg_valid_d   = (r_state_d == R_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q     <= W_IDLE;
            r_state_q     <= R_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            proto_err_q   <= 1'b0;
            pend_q        <= '0;
            store_start_q <= 1'b0;
            store_end_q   <= 1'b0;
            start_q       <= '0;
            end_q         <= '0;
            addr_q        <= '0;
            re_q          <= 1'b0;
            msg_valid_q   <= 1'b0;
        end else begin
            w_state_q     <= w_state_d;
            r_state_q     <= r_state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            proto_err_q   <= proto_err_d;
            pend_q        <= pend_d;
            store_start_q <= store_start_d;
            store_end_q   <= store_end_d;
            start_q       <= start_d;
            end_q         <= end_d;
            addr_q        <= addr_d;
            re_q          <= re_d;
            msg_valid_q   <= msg_valid_d;
        end
    end

    assign store_start_o = store_start_q;
    assign store_end_o   = store_end_q;
    assign start_o       = start_q;
    assign end_o         = end_q;
    assign addr_o        = addr_q;
    assign re_o          = re_q;
    assign read_start_o  = re_q;
    assign read_end_o    = re_q;
    assign msg_valid_o   = msg_valid_q;
    assign msg_start_o   = mem_start_i;
    assign msg_end_o     = mem_end_i;
    assign count_o       = count_q;
    assign full_o        = (count_q == NUM_CNT);
    assign overflow_o    = overflow_q;
    assign proto_err_o   = proto_err_q;

`ifdef MSG_LOC_STATS_EN
    logic [15:0] stat_commit_q, stat_commit_d, stat_drop_q, stat_drop_d;

    always_comb begin
        stat_commit_d = stat_commit_q;
        stat_drop_d   = stat_drop_q;
        if (commit && stat_commit_q != 16'hFFFF) stat_commit_d = stat_commit_q + 16'd1;
        if (drop && stat_drop_q != 16'hFFFF)     stat_drop_d   = stat_drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_commit_q <= '0;
            stat_drop_q   <= '0;
        end else begin
            stat_commit_q <= stat_commit_d;
            stat_drop_q   <= stat_drop_d;
        end
    end

    assign stat_commit_o = stat_commit_q;
    assign stat_drop_o   = stat_drop_q;
`endif
endmodule

// File: tb/tb_message_loc_ctrl.sv
// Bench for message_loc_ctrl: queue-level reference of committed messages and expected store
// writes, checked every cycle, plus directed literal expectations.
module tb_message_loc_ctrl;
    localparam int DW = 5;
    localparam int NM = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          msg_begin_i = 1'b0, msg_end_i = 1'b0, msg_ready_i = 1'b0;
    logic [DW-1:0] pos_i = '0;
    logic          store_start_o, store_end_o, re_o, read_start_o, read_end_o;
    logic [DW-1:0] start_o, end_o, msg_start_o, msg_end_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] mem_start_i = '0, mem_end_i = '0;
    logic          msg_valid_o, full_o, overflow_o, proto_err_o;
    logic [AW:0]   count_o;
`ifdef MSG_LOC_STATS_EN
    logic [15:0]   stat_commit_o, stat_drop_o;
`endif

    message_loc_ctrl #(.DATA_WIDTH(DW), .NUM_MESSAGE(NM), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .msg_begin_i(msg_begin_i), .msg_end_i(msg_end_i), .pos_i(pos_i),
        .store_start_o(store_start_o), .store_end_o(store_end_o), .start_o(start_o), .end_o(end_o),
        .addr_o(addr_o), .re_o(re_o), .read_start_o(read_start_o), .read_end_o(read_end_o),
        .mem_start_i(mem_start_i), .mem_end_i(mem_end_i), .msg_valid_o(msg_valid_o),
        .msg_ready_i(msg_ready_i), .msg_start_o(msg_start_o), .msg_end_o(msg_end_o),
        .count_o(count_o), .full_o(full_o), .overflow_o(overflow_o), .proto_err_o(proto_err_o)
`ifdef MSG_LOC_STATS_EN
        , .stat_commit_o(stat_commit_o), .stat_drop_o(stat_drop_o)
`endif
    );

    always #5 clk = ~clk;

    // Location store: write strobes land in the slot arrays, reads return registered data.
    logic [DW-1:0] st_s [16];
    logic [DW-1:0] st_e [16];
    always @(posedge clk) begin
        if (store_start_o) st_s[addr_o] <= start_o;
        if (store_end_o)   st_e[addr_o] <= end_o;
        if (re_o) begin
            mem_start_i <= st_s[addr_o];
            mem_end_i   <= st_e[addr_o];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: committed messages in order, current message, and the stream of store writes
    // (one per cycle, in event order, each due no earlier than the cycle after its event).
    typedef struct { bit is_end; int addr; int pos; int due; } ew_t;
    ew_t exp_wr[$];
    int  q_s[$];
    int  q_e[$];
    bit  in_msg, dropping, ovf_m, perr_m, chk_en;
    int  cur_start, wr_ptr_m, rd_ptr_m, cyc, last_due, nf;
    bit  hs;
    ew_t ew;

    task automatic model_reset();
        in_msg = 0; dropping = 0; ovf_m = 0; perr_m = 0;
        wr_ptr_m = 0; rd_ptr_m = 0; last_due = 0;
        q_s.delete(); q_e.delete(); exp_wr.delete();
    endtask

    task automatic push_wr(input bit is_end, input int addr, input int pos);
        ew_t w;
        nf = (last_due + 1 > cyc + 1) ? last_due + 1 : cyc + 1;
        w.is_end = is_end; w.addr = addr; w.pos = pos; w.due = nf;
        last_due = nf;
        exp_wr.push_back(w);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("count", count_o, q_s.size());
            chk("full", full_o, q_s.size() == NM);
            chk("overflow", overflow_o, ovf_m);
            chk("proto_err", proto_err_o, perr_m);
            chk("strobe_excl", store_start_o && store_end_o, 0);
            chk("strobe_vs_re", (store_start_o || store_end_o) && re_o, 0);
            chk("re_fields", {read_start_o, read_end_o}, {re_o, re_o});
            if (exp_wr.size() > 0 && exp_wr[0].due == cyc) begin
                ew = exp_wr.pop_front();
                chk("wr_start_strobe", store_start_o, !ew.is_end);
                chk("wr_end_strobe", store_end_o, ew.is_end);
                chk("wr_addr", addr_o, ew.addr);
                chk("wr_data", ew.is_end ? end_o : start_o, ew.pos);
            end else begin
                chk("no_strobe", store_start_o || store_end_o, 0);
            end
            if (re_o) begin
                chk("rd_addr", addr_o, rd_ptr_m);
                chk("rd_nonempty", q_s.size() > 0, 1);
            end
            if (msg_valid_o) chk("valid_nonempty", q_s.size() > 0, 1);
        end
        if (!rst) begin
            model_reset();
        end else if (chk_en) begin
            hs = msg_valid_o && msg_ready_i;
            if (hs) begin
                chk("pop_nonempty", q_s.size() > 0, 1);
                if (q_s.size() > 0) begin
                    chk("pop_start", msg_start_o, q_s[0]);
                    chk("pop_end", msg_end_o, q_e[0]);
                end
            end
            if (msg_end_i) begin
                if (in_msg) begin
                    push_wr(1, wr_ptr_m, pos_i);
                    q_s.push_back(cur_start);
                    q_e.push_back(int'(pos_i));
                    wr_ptr_m = (wr_ptr_m + 1) % NM;
                    in_msg = 0;
                end else if (dropping) begin
                    dropping = 0;
                end else begin
                    perr_m = 1;
                end
            end
            if (msg_begin_i) begin
                if (in_msg) begin
                    perr_m = 1;
                    cur_start = pos_i;
                    push_wr(0, wr_ptr_m, pos_i);
                end else if (!dropping) begin
                    if (q_s.size() >= NM) begin
                        ovf_m = 1;
                        dropping = 1;
                    end else begin
                        in_msg = 1;
                        cur_start = pos_i;
                        push_wr(0, wr_ptr_m, pos_i);
                    end
                end
            end
            if (hs && q_s.size() > 0) begin
                void'(q_s.pop_front());
                void'(q_e.pop_front());
                rd_ptr_m = (rd_ptr_m + 1) % NM;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ev(input bit b, input bit e, input int p);
        msg_begin_i = b;
        msg_end_i   = e;
        pos_i       = p[DW-1:0];
        step();
        msg_begin_i = 0;
        msg_end_i   = 0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (count_o != 0 && n < 200) begin
            step();
            n++;
        end
        chk(name, count_o, 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (msg_valid_o !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk(name, msg_valid_o, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1;
        chk("rst_count", count_o, 0);
        chk("rst_valid", msg_valid_o, 0);
        chk("rst_re", re_o, 0);
        rst = 1;

        // 1: single message, start 3 / end 17, popped straight away
        msg_ready_i = 1;
        ev(1, 0, 3);
        chk("t1_start_strobe", store_start_o, 1);
        chk("t1_start_addr", addr_o, 0);
        chk("t1_start_data", start_o, 3);
        repeat (3) step();
        ev(0, 1, 17);
        chk("t1_end_strobe", store_end_o, 1);
        chk("t1_end_addr", addr_o, 0);
        chk("t1_end_data", end_o, 17);
        chk("t1_count1", count_o, 1);
        step();
        chk("t1_re", re_o, 1);
        chk("t1_re_addr", addr_o, 0);
        step();
        chk("t1_valid", msg_valid_o, 1);
        chk("t1_msg_start", msg_start_o, 3);
        chk("t1_msg_end", msg_end_o, 17);
        step();
        chk("t1_valid_drop", msg_valid_o, 0);
        chk("t1_count0", count_o, 0);

        // 2: fill all ten slots, then an eleventh message is dropped
        msg_ready_i = 0;
        for (int i = 0; i < NM; i++) begin
            ev(1, 0, i);
            ev(0, 1, i + 10);
        end
        repeat (2) step();
        chk("t2_full", full_o, 1);
        chk("t2_count10", count_o, 10);
        ev(1, 0, 25);
        chk("t2_drop_no_start", store_start_o, 0);
        chk("t2_overflow", overflow_o, 1);
        ev(0, 1, 26);
        chk("t2_drop_no_end", store_end_o, 0);
        chk("t2_count_held", count_o, 10);
        msg_ready_i = 1;
        wait_empty("t2_drain");

        // 3: twelve commit/pop pairs, both pointers wrap 9 -> 0
        for (int i = 0; i < 12; i++) begin
            ev(1, 0, i + 1);
            if (i == 9) chk("t3_wrap_wr0", addr_o, 0);
            ev(0, 1, i + 20);
            if (i == 8) chk("t3_wr_slot9", addr_o, 9);
            wait_empty("t3_pop");
        end

        // 4: end event while a read is pending: strobe first, read the cycle after
        msg_ready_i = 0;
        ev(1, 0, 1);
        ev(0, 1, 2);
        ev(1, 0, 4);
        ev(0, 1, 6);
        repeat (4) step();
        ev(1, 0, 7);
        repeat (2) step();
        msg_ready_i = 1;
        step();
        msg_ready_i = 0;
        ev(0, 1, 9);
        chk("t4_end_first", store_end_o, 1);
        chk("t4_no_re", re_o, 0);
        chk("t4_end_addr", addr_o, 5);
        chk("t4_end_data", end_o, 9);
        step();
        chk("t4_re_after", re_o, 1);
        chk("t4_re_addr", addr_o, 4);
        msg_ready_i = 1;
        wait_empty("t4_drain");

        // 5: protocol errors; restarted slot keeps the last start
        msg_ready_i = 0;
        ev(0, 1, 3);
        chk("t5_perr", proto_err_o, 1);
        ev(1, 0, 5);
        ev(1, 0, 8);
        ev(0, 1, 20);
        chk("t5_count1", count_o, 1);
        wait_valid("t5_valid");
        chk("t5_msg_start", msg_start_o, 8);
        chk("t5_msg_end", msg_end_o, 20);
        msg_ready_i = 1;
        wait_empty("t5_drain");

        // begin and end together: end written now, new start one cycle later
        ev(1, 0, 2);
        step();
        ev(1, 1, 11);
        chk("t5b_end_now", store_end_o, 1);
        chk("t5b_no_start", store_start_o, 0);
        step();
        chk("t5b_start_deferred", store_start_o, 1);
        chk("t5b_start_data", start_o, 11);
        ev(0, 1, 30);
        wait_empty("t5b_drain");

        // 6: reset mid-message with three queued
        msg_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            ev(1, 0, i);
            ev(0, 1, i + 4);
        end
        ev(1, 0, 12);
        step();
        chk("t6_count3", count_o, 3);
        rst = 0;
        step();
        chk("t6_count", count_o, 0);
        chk("t6_full", full_o, 0);
        chk("t6_ovf", overflow_o, 0);
        chk("t6_perr", proto_err_o, 0);
        chk("t6_strobes", {store_start_o, store_end_o, re_o, read_start_o, read_end_o}, 0);
        chk("t6_valid", msg_valid_o, 0);
        chk("t6_addr", addr_o, 0);
        chk("t6_data", {start_o, end_o}, 0);
`ifdef MSG_LOC_STATS_EN
        chk("t6_stat_commit", stat_commit_o, 0);
        chk("t6_stat_drop", stat_drop_o, 0);
`endif
        rst = 1;
        step();
        chk("t6_count_after", count_o, 0);
        ev(0, 1, 5);
        chk("t6_partial_gone", proto_err_o, 1);
        repeat (3) step();

        chk("wr_drained", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
